// File: rtl/axi4_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns register read/write commands into
// AXI4-Lite transactions and returns data/response on a valid/ready channel.
module axi4_lite_cmd_master #(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           AXI_DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] AXI_BASE_ADDR  = '0,
  parameter int unsigned           TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  // AXI4-Lite master port
  output logic [ADDR_WIDTH-1:0]       o_awaddr,
  output logic [2:0]                  o_awprot,
  output logic                        o_awvalid,
  input  logic                        i_awready,
  output logic [AXI_DATA_WIDTH-1:0]   o_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] o_wstrb,
  output logic                        o_wvalid,
  input  logic                        i_wready,
  input  logic [1:0]                  i_bresp,
  input  logic                        i_bvalid,
  output logic                        o_bready,
  output logic [ADDR_WIDTH-1:0]       o_araddr,
  output logic [2:0]                  o_arprot,
  output logic                        o_arvalid,
  input  logic                        i_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   i_rdata,
  input  logic [1:0]                  i_rresp,
  input  logic                        i_rvalid,
  output logic                        o_rready,
  // command channel
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic                        i_cmd_write,
  input  logic [ADDR_WIDTH-1:0]       i_cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   i_cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] i_cmd_wstrb,
  // response channel
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic                        o_rsp_write,
  output logic [AXI_DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]                  o_rsp_resp,
  output logic                        o_timeout
);

  localparam int unsigned STRB_W     = AXI_DATA_WIDTH / 8;
  localparam int unsigned CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [1:0]  AXI4_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP
  } state_e;

  state_e                    state_q;
  logic [ADDR_WIDTH-1:0]     awaddr_q, araddr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, rsp_rdata_q;
  logic [STRB_W-1:0]         wstrb_q;
  logic                      awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                      rsp_valid_q, rsp_write_q, timeout_q;
  logic [1:0]                rsp_resp_q;
  logic [CNT_W-1:0]          wd_cnt_q;

  logic [ADDR_WIDTH-1:0]     cmd_addr_c;
  logic                      busy_c, aw_done_c, w_done_c;

  // Base offset wraps modulo the address width.
  assign cmd_addr_c = ADDR_WIDTH'(i_cmd_addr + AXI_BASE_ADDR);
  assign busy_c     = (state_q == WR) || (state_q == WR_RESP) ||
                      (state_q == RD_ADDR) || (state_q == RD_DATA);
  assign aw_done_c  = !awvalid_q || i_awready;
  assign w_done_c   = !wvalid_q || i_wready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= AXI4_RESP_OKAY;
      timeout_q   <= 1'b0;
      wd_cnt_q    <= '0;
    end else begin
      // Watchdog; the state-specific clears below take priority.
      if (busy_c) begin
        if (wd_cnt_q != CNT_MAX) wd_cnt_q <= wd_cnt_q + CNT_W'(1);
        timeout_q <= TIMEOUT_EN && (wd_cnt_q >= CNT_MAX);
      end

      unique case (state_q)
        IDLE: begin
          if (i_cmd_valid) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
            if (i_cmd_write) begin
              awaddr_q  <= cmd_addr_c;
              wdata_q   <= i_cmd_wdata;
              wstrb_q   <= i_cmd_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR;
            end else begin
              araddr_q  <= cmd_addr_c;
              arvalid_q <= 1'b1;
              state_q   <= RD_ADDR;
            end
          end
        end
        WR: begin
          // aw and w retire independently; leave once both are done.
          if (awvalid_q && i_awready) awvalid_q <= 1'b0;
          if (wvalid_q && i_wready)   wvalid_q  <= 1'b0;
          if (aw_done_c && w_done_c) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (i_bvalid) begin
            bready_q    <= 1'b0;
            rsp_write_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= i_bresp;
            rsp_valid_q <= 1'b1;
            wd_cnt_q    <= '0;
            timeout_q   <= 1'b0;
            state_q     <= RSP;
          end
        end
        RD_ADDR: begin
          if (i_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (i_rvalid) begin
            rready_q    <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= i_rdata;
            rsp_resp_q  <= i_rresp;
            rsp_valid_q <= 1'b1;
            wd_cnt_q    <= '0;
            timeout_q   <= 1'b0;
            state_q     <= RSP;
          end
        end
        RSP: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_awaddr    = awaddr_q;
  assign o_awprot    = 3'b000;
  assign o_awvalid   = awvalid_q;
  assign o_wdata     = wdata_q;
  assign o_wstrb     = wstrb_q;
  assign o_wvalid    = wvalid_q;
  assign o_bready    = bready_q;
  assign o_araddr    = araddr_q;
  assign o_arprot    = 3'b000;
  assign o_arvalid   = arvalid_q;
  assign o_rready    = rready_q;
  assign o_cmd_ready = (state_q == IDLE);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_write = rsp_write_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_resp  = rsp_resp_q;
  assign o_timeout   = timeout_q;

endmodule
